// File: rtl/glip_arb_pkg.sv
// Shared types and sizing helpers for the GLIP stream arbiter.
// Width helpers keep index and counter sizing consistent across users.
package glip_arb_pkg;

    typedef enum logic {
        ARB,
        BURST
    } state_e;

    function automatic int chan_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/glip_rr_select.sv
// Combinational round-robin picker: first set req at or after ptr.
// Reusable for any GLIP mux that needs a fair pointer-based choice.
module glip_rr_select
    import glip_arb_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]             req,
    input  logic [chan_width(CHANNELS)-1:0] ptr,
    output logic                            any,
    output logic [chan_width(CHANNELS)-1:0] idx
);

    localparam int CW = chan_width(CHANNELS);

    logic [CHANNELS-1:0] rot;
    logic [CW:0]         sum;

    always_comb begin
        any = |req;
        idx = '0;
        sum = '0;
        // rot[k] is the request of channel (ptr + k) mod CHANNELS
        rot = CHANNELS'({req, req} >> ptr);
        for (int off = CHANNELS - 1; off >= 0; off--) begin
            if (rot[off]) begin
                sum = {1'b0, ptr} + (CW + 1)'(off);
                if (sum >= (CW + 1)'(CHANNELS)) begin
                    sum = sum - (CW + 1)'(CHANNELS);
                end
                idx = sum[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/glip_stream_arbiter.sv
// Round-robin arbiter sharing one GLIP stream among CHANNELS sources.
// Bursts end on in_last or after MAX_BURST words; words carry their channel.
module glip_stream_arbiter
    import glip_arb_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS*WIDTH-1:0]       in_data,
    input  logic [CHANNELS-1:0]             in_valid,
    input  logic [CHANNELS-1:0]             in_last,
    output logic [CHANNELS-1:0]             in_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic [chan_width(CHANNELS)-1:0] out_chan,
    input  logic                            out_ready
);

    localparam int CW   = chan_width(CHANNELS);
    localparam int CNTW = cnt_width(MAX_BURST);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
    localparam logic [CW-1:0]   CH_LAST  = CW'(CHANNELS - 1);

    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("CHANNELS must be in 2..16");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CNTW-1:0] count_q, count_d;

    logic          sel_any;
    logic [CW-1:0] sel_idx;

    glip_rr_select #(
        .CHANNELS(CHANNELS)
    ) u_select (
        .req(in_valid),
        .ptr(ptr_q),
        .any(sel_any),
        .idx(sel_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            grant_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        count_d   = count_q;
        in_ready  = '0;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_chan  = '0;
        unique case (state_q)
            ARB: begin
                if (sel_any) begin
                    grant_d = sel_idx;
                    count_d = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                out_data  = WIDTH'(in_data >> (grant_q * WIDTH));
                out_valid = in_valid[grant_q];
                out_chan  = grant_q;
                out_last  = in_last[grant_q] | (count_q == CNT_LAST);
                in_ready[grant_q] = out_ready;
                // A gap on the granted source just stalls; the grant is held
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        count_d = '0;
                        state_d = ARB;
                        ptr_d   = (grant_q == CH_LAST) ? '0 : grant_q + 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

endmodule

// File: doc/glip_stream_arbiter.md
# glip_stream_arbiter

Round-robin arbiter that shares one GLIP FIFO-style output stream between CHANNELS requesters. It sits upstream of the width downscaler. Bursts are delimited by a per-channel last flag and capped at MAX_BURST words, and each output word is tagged with its source channel. The block never interleaves words of different channels inside a burst.

## Interface
- CHANNELS, 4: number of requesters, 2..16.
- WIDTH, 16: data word width in bits.
- MAX_BURST, 8: maximum words per grant, ≥1. A burst is forcibly ended after this many words.
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous and active-high.
- in_data  input  CHANNELS*WIDTH  channel i word at [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_last  input  CHANNELS  per-channel end-of-packet, qualified by in_valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high.
- out_data  output  WIDTH  granted word.
- out_valid  output  1  output valid.
- out_last  output  1  last word of the current burst.
- out_chan  output  CW  source channel index, where CW = max(1, $clog2(CHANNELS)).
- out_ready  input  1  downstream ready.

## Operation
- A transfer occurs on a channel or the output when valid & ready are both high at a posedge.
- The state machine has two states: ARB and BURST.
- ARB:
  - in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, out_chan = 0.
  - Winner = first channel with in_valid set, searching ptr, ptr+1, … mod CHANNELS.
  - If any in_valid is high: grant <= winner, count <= 0, go to BURST. Otherwise stay in ARB.
- BURST (combinational pass-through from channel g = grant):
  - out_data = in_data[g], out_valid = in_valid[g], out_chan = g.
  - in_ready[g] = out_ready; all other in_ready bits are 0.
  - out_last = in_last[g] | (count == MAX_BURST-1).
  - On each output transfer, count <= count+1.
  - On an output transfer with out_last: ptr <= (g+1) mod CHANNELS, go to ARB.
  - If in_valid[g] drops mid-burst, the grant is held; the burst does not end early.
- A burst cut at MAX_BURST marks out_last even if in_last is 0. The channel's remaining words continue in a later grant.
- count is wide enough to hold MAX_BURST-1. It never wraps inside a burst.

## Timing
- Reset values: state ARB, ptr 0, grant 0, count 0. All outputs are 0, in_ready is 0.
- rst asserted mid-burst drops the burst immediately. Outputs are 0 in the cycle after the reset edge. Partially sent packets are not replayed.
- Arbitration costs exactly one bubble cycle per burst. The first word of a burst appears on the output the cycle after the ARB cycle that saw in_valid.
- Latency inside a burst is zero (combinational valid/ready/data path). Throughput is 1 word/cycle while out_ready is high.
- Sustained throughput with back-to-back single-word bursts is 50%.
- Simultaneous requests are resolved by ptr, so no channel waits more than CHANNELS-1 bursts.
- When in_last and the MAX_BURST limit coincide, there is a single end of burst and out_last = 1.
- out_ready low holds all outputs stable as long as in_valid[g] and in_data[g] are held by the source.

## Structure
- Package glip_arb_pkg:
  - state enum {ARB, BURST}.
  - Function for chan_width(CHANNELS) = max(1, $clog2(CHANNELS)).
- Sub-module glip_rr_select: combinational round-robin picker.
  - Inputs: req[CHANNELS], ptr.
  - Outputs: any, idx.
  - Instantiated once. Reusable for other GLIP muxes.
- Top level holds the state register, grant, ptr, count, and the output muxing.

## Test plan
- Single channel: ch1 sends 3 words 0x1111/0x2222/0x3333 with in_last on the third, out_ready=1.
  - Expect one ARB bubble, then 3 consecutive outputs with out_chan=1 and out_last on 0x3333.
  - ptr becomes 2.
- Contention: ch0 and ch2 each present a 2-word packet from reset.
  - Expect ch0's burst, a bubble, then ch2's burst, in that order.
  - A second round started with ptr=1 serves ch2 before ch0.
- Cap: MAX_BURST=4, ch3 sends 6 words with last on word 6.
  - Expect a burst of 4 with out_last on word 4, then a new grant to ch3 for 2 words with out_last on word 6.
- Backpressure: out_ready low for 3 cycles mid-burst.
  - out_data, out_chan and out_valid stay stable, in_ready[g]=0, count unchanged.
  - On release, no words are lost or duplicated.
- Gap: in_valid[g] drops for 2 cycles mid-packet while another channel requests.
  - Grant is held, no other channel is served, and the burst resumes on the same channel.
- Reset: assert rst on word 2 of a 5-word burst.
  - Next cycle all outputs and in_ready are 0 and state is ARB.
  - The following arbitration starts from ptr 0.
